// File: rtl/rshift_seq_if.sv
// Handshake and data bundle between the ALU controller and the sequential
// right shifter.
//   start        controller -> shifter  request, sampled only while the shifter is idle
//   arith        controller -> shifter  1 = sign fill, 0 = zero fill
//   data_in      controller -> shifter  operand, captured on the accepted start
//   shift_amount controller -> shifter  shift distance, captured on the accepted start
//   busy         shifter -> controller  high while shifting
//   done         shifter -> controller  one-cycle pulse, data_out valid
//   data_out     shifter -> controller  result, held until the next completion
interface rshift_seq_if #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned SHAMT_W = 6
);
   logic               start;
   logic               arith;
   logic [WIDTH-1:0]   data_in;
   logic [SHAMT_W-1:0] shift_amount;
   logic               busy;
   logic               done;
   logic [WIDTH-1:0]   data_out;

   modport master (
      output start, arith, data_in, shift_amount,
      input  busy, done, data_out
   );

   modport slave (
      input  start, arith, data_in, shift_amount,
      output busy, done, data_out
   );
endinterface

// File: rtl/rshift_seq.sv
// Multi-cycle right shifter (SRL/SRA) moving one bit position per clock.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous, active-high reset
//   bus  rshift_seq_if slave modport: start/arith/data_in/shift_amount in,
//        busy/done/data_out out
// An operation of distance n (clamped to WIDTH) takes n SHIFT cycles followed
// by a single DONE cycle; a zero distance goes straight from IDLE to DONE.
module rshift_seq #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned SHAMT_W = 6
) (
   input logic         clk,
   input logic         rst,
   rshift_seq_if.slave bus
);

   localparam int unsigned CntW = $clog2(WIDTH + 1);
   // One extra bit so the clamp compare also works when 2**SHAMT_W == WIDTH.
   localparam logic [SHAMT_W:0] WidthAmt = (SHAMT_W + 1)'(WIDTH);

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StShift = 2'd1;
   localparam logic [1:0] StDone  = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             arith_q, arith_d;
   logic [WIDTH-1:0] data_out_q, data_out_d;

   logic [CntW-1:0]  cnt_init;
   logic [WIDTH-1:0] shifted;

   // Distances of WIDTH or more saturate to WIDTH shift cycles.
   always_comb begin
      if ({1'b0, bus.shift_amount} >= WidthAmt) begin
         cnt_init = CntW'(WIDTH);
      end else begin
         cnt_init = CntW'(bus.shift_amount);
      end
   end

   assign shifted = {(arith_q ? shreg_q[WIDTH-1] : 1'b0), shreg_q[WIDTH-1:1]};

   always_comb begin
      state_d    = state_q;
      shreg_d    = shreg_q;
      cnt_d      = cnt_q;
      arith_d    = arith_q;
      data_out_d = data_out_q;
      case (state_q)
         StIdle: begin
            if (bus.start) begin
               shreg_d = bus.data_in;
               arith_d = bus.arith;
               cnt_d   = cnt_init;
               if (cnt_init == '0) begin
                  state_d    = StDone;
                  data_out_d = bus.data_in;
               end else begin
                  state_d = StShift;
               end
            end
         end
         StShift: begin
            shreg_d = shifted;
            cnt_d   = cnt_q - CntW'(1);
            // Result is registered on the same edge that enters DONE.
            if (cnt_q == CntW'(1)) begin
               state_d    = StDone;
               data_out_d = shifted;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         shreg_q    <= '0;
         cnt_q      <= '0;
         arith_q    <= 1'b0;
         data_out_q <= '0;
      end else begin
         state_q    <= state_d;
         shreg_q    <= shreg_d;
         cnt_q      <= cnt_d;
         arith_q    <= arith_d;
         data_out_q <= data_out_d;
      end
   end

   assign bus.busy     = (state_q == StShift);
   assign bus.done     = (state_q == StDone);
   assign bus.data_out = data_out_q;

endmodule

// File: tb/tb_rshift_seq.sv
// Directed bench for rshift_seq: each task drives one scenario and checks
// its own hand-computed results.
module tb_rshift_seq;
   localparam int unsigned WIDTH   = 32;
   localparam int unsigned SHAMT_W = 6;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   rshift_seq_if #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) bus ();

   rshift_seq #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Waits for idle, presents an operation for one accepting edge.
   // Returns at accepting edge + 1.
   task automatic start_op(input logic [31:0] d, input logic [5:0] sh, input logic ar);
      int guard = 0;
      while ((bus.busy || bus.done) && guard < 100) begin
         @(posedge clk); #1;
         guard++;
      end
      bus.data_in      = d;
      bus.shift_amount = sh;
      bus.arith        = ar;
      bus.start        = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
   endtask

   // Counts edges (and busy cycles) from now until done is seen; bounded.
   task automatic wait_done(output int edges, output int busy_cycles);
      edges       = 0;
      busy_cycles = 0;
      while (!bus.done && edges < 100) begin
         if (bus.busy) busy_cycles++;
         @(posedge clk); #1;
         edges++;
      end
   endtask

   task automatic test_reset();
      bus.start        = 1'b0;
      bus.arith        = 1'b0;
      bus.data_in      = '0;
      bus.shift_amount = '0;
      rst              = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (bus.busy !== 1'b0) begin
         errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy);
      end
      checks++;
      if (bus.done !== 1'b0) begin
         errors++; $display("FAIL reset_done: got %b expected 0", bus.done);
      end
      checks++;
      if (bus.data_out !== 32'h0) begin
         errors++; $display("FAIL reset_data_out: got %h expected 00000000", bus.data_out);
      end
      rst = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
         errors++; $display("FAIL reset_idle: got busy=%b done=%b expected 0/0", bus.busy, bus.done);
      end
   endtask

   task automatic test_logical();
      int e, b;
      start_op(32'hF000_0000, 6'd4, 1'b0);
      wait_done(e, b);
      checks++;
      if (e !== 4) begin
         errors++; $display("FAIL logical_latency: got %0d edges expected 4", e);
      end
      checks++;
      if (b !== 4) begin
         errors++; $display("FAIL logical_busy_cycles: got %0d expected 4", b);
      end
      checks++;
      if (bus.data_out !== 32'h0F00_0000) begin
         errors++; $display("FAIL logical_data: got %h expected 0f000000", bus.data_out);
      end
      checks++;
      if (bus.busy !== 1'b0) begin
         errors++; $display("FAIL logical_busy_with_done: got %b expected 0", bus.busy);
      end
      @(posedge clk); #1;
      checks++;
      if (bus.done !== 1'b0) begin
         errors++; $display("FAIL logical_done_pulse: got %b expected 0", bus.done);
      end
      checks++;
      if (bus.data_out !== 32'h0F00_0000) begin
         errors++; $display("FAIL logical_hold: got %h expected 0f000000", bus.data_out);
      end
   endtask

   task automatic test_arith();
      int e, b;
      start_op(32'h8000_0010, 6'd4, 1'b1);
      wait_done(e, b);
      checks++;
      if (e !== 4) begin
         errors++; $display("FAIL arith_latency: got %0d edges expected 4", e);
      end
      checks++;
      if (bus.data_out !== 32'hF800_0001) begin
         errors++; $display("FAIL arith_data: got %h expected f8000001", bus.data_out);
      end
   endtask

   task automatic test_zero();
      int e, b;
      start_op(32'h1234_5678, 6'd0, 1'b0);
      wait_done(e, b);
      // Done is already up right after the edge that sampled start.
      checks++;
      if (e !== 0) begin
         errors++; $display("FAIL zero_latency: got %0d extra edges expected 0", e);
      end
      checks++;
      if (b !== 0) begin
         errors++; $display("FAIL zero_busy: got %0d busy cycles expected 0", b);
      end
      checks++;
      if (bus.data_out !== 32'h1234_5678) begin
         errors++; $display("FAIL zero_data: got %h expected 12345678", bus.data_out);
      end
   endtask

   task automatic test_boundary();
      int e, b;
      start_op(32'h8000_0000, 6'd1, 1'b1);
      wait_done(e, b);
      checks++;
      if (e !== 1 || bus.data_out !== 32'hC000_0000) begin
         errors++;
         $display("FAIL shift1_arith: got %0d edges data %h expected 1 edges data c0000000",
                  e, bus.data_out);
      end
      start_op(32'hFFFF_FFFF, 6'd32, 1'b0);
      wait_done(e, b);
      checks++;
      if (e !== 32 || bus.data_out !== 32'h0) begin
         errors++;
         $display("FAIL shift32_logical: got %0d edges data %h expected 32 edges data 00000000",
                  e, bus.data_out);
      end
   endtask

   task automatic test_saturation();
      int e, b;
      start_op(32'h8000_0000, 6'd63, 1'b1);
      wait_done(e, b);
      checks++;
      if (e !== 32 || bus.data_out !== 32'hFFFF_FFFF) begin
         errors++;
         $display("FAIL sat_arith: got %0d edges data %h expected 32 edges data ffffffff",
                  e, bus.data_out);
      end
      start_op(32'h8000_0000, 6'd63, 1'b0);
      wait_done(e, b);
      checks++;
      if (e !== 32 || bus.data_out !== 32'h0) begin
         errors++;
         $display("FAIL sat_logical: got %0d edges data %h expected 32 edges data 00000000",
                  e, bus.data_out);
      end
   endtask

   task automatic test_back_to_back();
      int e, b;
      @(posedge clk); #1;
      bus.data_in      = 32'h0000_00F0;
      bus.shift_amount = 6'd4;
      bus.arith        = 1'b0;
      bus.start        = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (bus.busy !== 1'b1) begin
         errors++; $display("FAIL b2b_accept: got busy=%b expected 1", bus.busy);
      end
      // New operands while shifting; start stays high throughout.
      bus.data_in      = 32'h8000_0000;
      bus.shift_amount = 6'd2;
      bus.arith        = 1'b1;
      wait_done(e, b);
      checks++;
      if (e !== 4 || bus.data_out !== 32'h0000_000F) begin
         errors++;
         $display("FAIL b2b_first: got %0d edges data %h expected 4 edges data 0000000f",
                  e, bus.data_out);
      end
      @(posedge clk); #1;
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.data_out !== 32'h0000_000F) begin
         errors++;
         $display("FAIL b2b_idle_gap: got busy=%b done=%b data %h expected 0/0/0000000f",
                  bus.busy, bus.done, bus.data_out);
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
      checks++;
      if (bus.busy !== 1'b1) begin
         errors++; $display("FAIL b2b_second_accept: got busy=%b expected 1", bus.busy);
      end
      wait_done(e, b);
      checks++;
      if (e !== 2 || bus.data_out !== 32'hE000_0000) begin
         errors++;
         $display("FAIL b2b_second: got %0d edges data %h expected 2 edges data e0000000",
                  e, bus.data_out);
      end
   endtask

   task automatic test_reset_abort();
      int e, b;
      bit saw_done = 1'b0;
      start_op(32'hFFFF_0000, 6'd8, 1'b0);
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.data_out !== 32'h0) begin
         errors++;
         $display("FAIL abort_clear: got busy=%b done=%b data %h expected 0/0/00000000",
                  bus.busy, bus.done, bus.data_out);
      end
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (i == 3) rst = 1'b0;
         if (bus.done) saw_done = 1'b1;
      end
      checks++;
      if (saw_done !== 1'b0 || bus.data_out !== 32'h0) begin
         errors++;
         $display("FAIL abort_no_done: got done_seen=%b data %h expected 0/00000000",
                  saw_done, bus.data_out);
      end
      start_op(32'h0000_FF00, 6'd8, 1'b0);
      wait_done(e, b);
      checks++;
      if (e !== 8 || bus.data_out !== 32'h0000_00FF) begin
         errors++;
         $display("FAIL abort_restart: got %0d edges data %h expected 8 edges data 000000ff",
                  e, bus.data_out);
      end
   endtask

   initial begin
      test_reset();
      test_logical();
      test_arith();
      test_zero();
      test_boundary();
      test_saturation();
      test_back_to_back();
      test_reset_abort();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
